// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage RV32 core with load-use hazard detection.
// Injects one bubble per load-use hazard, honours branch flush and memory stall, and counts hazard bubbles.
module id_ex_stage #(
   parameter int XLEN   = 32,
   parameter int CTRL_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              dec_valid,
   input  logic [XLEN-1:0]   dec_pc,
   input  logic [4:0]        dec_rs1,
   input  logic [4:0]        dec_rs2,
   input  logic              dec_uses_rs1,
   input  logic              dec_uses_rs2,
   input  logic [4:0]        dec_rd,
   input  logic [XLEN-1:0]   dec_rd1,
   input  logic [XLEN-1:0]   dec_rd2,
   input  logic [XLEN-1:0]   dec_imm,
   input  logic [CTRL_W-1:0] dec_ctrl,
   input  logic              dec_mem_read,
   input  logic              dec_reg_write,
   input  logic              flush,
   input  logic              ext_stall,
   output logic              ex_valid,
   output logic [XLEN-1:0]   ex_pc,
   output logic [XLEN-1:0]   ex_rd1,
   output logic [XLEN-1:0]   ex_rd2,
   output logic [XLEN-1:0]   ex_imm,
   output logic [4:0]        ex_rs1,
   output logic [4:0]        ex_rs2,
   output logic [4:0]        ex_rd,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic              ex_mem_read,
   output logic              ex_reg_write,
   output logic              hold_id,
   output logic [CNT_W-1:0]  stall_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic              ex_valid_r,     ex_valid_nxt_s;
   logic [XLEN-1:0]   ex_pc_r,        ex_pc_nxt_s;
   logic [XLEN-1:0]   ex_rd1_r,       ex_rd1_nxt_s;
   logic [XLEN-1:0]   ex_rd2_r,       ex_rd2_nxt_s;
   logic [XLEN-1:0]   ex_imm_r,       ex_imm_nxt_s;
   logic [4:0]        ex_rs1_r,       ex_rs1_nxt_s;
   logic [4:0]        ex_rs2_r,       ex_rs2_nxt_s;
   logic [4:0]        ex_rd_r,        ex_rd_nxt_s;
   logic [CTRL_W-1:0] ex_ctrl_r,      ex_ctrl_nxt_s;
   logic              ex_mem_read_r,  ex_mem_read_nxt_s;
   logic              ex_reg_write_r, ex_reg_write_nxt_s;
   logic [CNT_W-1:0]  stall_count_r,  stall_count_nxt_s;
   logic              hazard_s;
   logic              rs1_match_s;
   logic              rs2_match_s;

   // Load-use hazard detection and ID hold; x0 is never a hazard source
   always_comb begin
      rs1_match_s = dec_uses_rs1 & (dec_rs1 == ex_rd_r);
      rs2_match_s = dec_uses_rs2 & (dec_rs2 == ex_rd_r);
      hazard_s    = ex_valid_r & ex_mem_read_r & (ex_rd_r != 5'd0) & dec_valid
                    & (rs1_match_s | rs2_match_s);
      hold_id     = ext_stall | (hazard_s & ~flush);
   end

   // Next-state selection: flush > ext_stall > hazard bubble > normal load
   always_comb begin
      ex_valid_nxt_s     = 1'b0;
      ex_pc_nxt_s        = '0;
      ex_rd1_nxt_s       = '0;
      ex_rd2_nxt_s       = '0;
      ex_imm_nxt_s       = '0;
      ex_rs1_nxt_s       = 5'd0;
      ex_rs2_nxt_s       = 5'd0;
      ex_rd_nxt_s        = 5'd0;
      ex_ctrl_nxt_s      = '0;
      ex_mem_read_nxt_s  = 1'b0;
      ex_reg_write_nxt_s = 1'b0;
      stall_count_nxt_s  = stall_count_r;
      if (flush) begin
         ex_valid_nxt_s = 1'b0;
      end else if (ext_stall) begin
         ex_valid_nxt_s     = ex_valid_r;
         ex_pc_nxt_s        = ex_pc_r;
         ex_rd1_nxt_s       = ex_rd1_r;
         ex_rd2_nxt_s       = ex_rd2_r;
         ex_imm_nxt_s       = ex_imm_r;
         ex_rs1_nxt_s       = ex_rs1_r;
         ex_rs2_nxt_s       = ex_rs2_r;
         ex_rd_nxt_s        = ex_rd_r;
         ex_ctrl_nxt_s      = ex_ctrl_r;
         ex_mem_read_nxt_s  = ex_mem_read_r;
         ex_reg_write_nxt_s = ex_reg_write_r;
      end else if (hazard_s) begin
         if (stall_count_r != CNT_MAX) begin
            stall_count_nxt_s = stall_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            stall_count_nxt_s = stall_count_r;
         end
      end else begin
         // Invalid slots still carry fields but must never write or load
         ex_valid_nxt_s     = dec_valid;
         ex_pc_nxt_s        = dec_pc;
         ex_rd1_nxt_s       = dec_rd1;
         ex_rd2_nxt_s       = dec_rd2;
         ex_imm_nxt_s       = dec_imm;
         ex_rs1_nxt_s       = dec_rs1;
         ex_rs2_nxt_s       = dec_rs2;
         ex_rd_nxt_s        = dec_rd;
         ex_ctrl_nxt_s      = dec_ctrl;
         ex_mem_read_nxt_s  = dec_mem_read & dec_valid;
         ex_reg_write_nxt_s = dec_reg_write & dec_valid;
      end
   end

   // Pipeline register and stall counter with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_valid_r     <= 1'b0;
         ex_pc_r        <= '0;
         ex_rd1_r       <= '0;
         ex_rd2_r       <= '0;
         ex_imm_r       <= '0;
         ex_rs1_r       <= 5'd0;
         ex_rs2_r       <= 5'd0;
         ex_rd_r        <= 5'd0;
         ex_ctrl_r      <= '0;
         ex_mem_read_r  <= 1'b0;
         ex_reg_write_r <= 1'b0;
         stall_count_r  <= '0;
      end else begin
         ex_valid_r     <= ex_valid_nxt_s;
         ex_pc_r        <= ex_pc_nxt_s;
         ex_rd1_r       <= ex_rd1_nxt_s;
         ex_rd2_r       <= ex_rd2_nxt_s;
         ex_imm_r       <= ex_imm_nxt_s;
         ex_rs1_r       <= ex_rs1_nxt_s;
         ex_rs2_r       <= ex_rs2_nxt_s;
         ex_rd_r        <= ex_rd_nxt_s;
         ex_ctrl_r      <= ex_ctrl_nxt_s;
         ex_mem_read_r  <= ex_mem_read_nxt_s;
         ex_reg_write_r <= ex_reg_write_nxt_s;
         stall_count_r  <= stall_count_nxt_s;
      end
   end

   assign ex_valid     = ex_valid_r;
   assign ex_pc        = ex_pc_r;
   assign ex_rd1       = ex_rd1_r;
   assign ex_rd2       = ex_rd2_r;
   assign ex_imm       = ex_imm_r;
   assign ex_rs1       = ex_rs1_r;
   assign ex_rs2       = ex_rs2_r;
   assign ex_rd        = ex_rd_r;
   assign ex_ctrl      = ex_ctrl_r;
   assign ex_mem_read  = ex_mem_read_r;
   assign ex_reg_write = ex_reg_write_r;
   assign stall_count  = stall_count_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus random traffic against a transaction-level model.
// A second instance with a 2-bit counter shares the stimulus to exercise saturation.
module tb_id_ex_stage;
   localparam int XLEN = 32;
   localparam int CTRL_W = 8;
   localparam int CNT_W = 16;
   localparam int SAT_W = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset, dec_valid, dec_uses_rs1, dec_uses_rs2, dec_mem_read, dec_reg_write, flush, ext_stall;
   logic [XLEN-1:0] dec_pc, dec_rd1, dec_rd2, dec_imm;
   logic [4:0] dec_rs1, dec_rs2, dec_rd;
   logic [CTRL_W-1:0] dec_ctrl;

   logic ex_valid, ex_mem_read, ex_reg_write, hold_id;
   logic [XLEN-1:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
   logic [4:0] ex_rs1, ex_rs2, ex_rd;
   logic [CTRL_W-1:0] ex_ctrl;
   logic [CNT_W-1:0] stall_count;

   logic s_ex_valid, s_ex_mem_read, s_ex_reg_write, s_hold_id;
   logic [XLEN-1:0] s_ex_pc, s_ex_rd1, s_ex_rd2, s_ex_imm;
   logic [4:0] s_ex_rs1, s_ex_rs2, s_ex_rd;
   logic [CTRL_W-1:0] s_ex_ctrl;
   logic [SAT_W-1:0] s_stall_count;

   id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_rs1(dec_rs1),
      .dec_rs2(dec_rs2), .dec_uses_rs1(dec_uses_rs1), .dec_uses_rs2(dec_uses_rs2), .dec_rd(dec_rd),
      .dec_rd1(dec_rd1), .dec_rd2(dec_rd2), .dec_imm(dec_imm), .dec_ctrl(dec_ctrl),
      .dec_mem_read(dec_mem_read), .dec_reg_write(dec_reg_write), .flush(flush), .ext_stall(ext_stall),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .ex_mem_read(ex_mem_read),
      .ex_reg_write(ex_reg_write), .hold_id(hold_id), .stall_count(stall_count));

   id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(SAT_W)) dut_sat (
      .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_rs1(dec_rs1),
      .dec_rs2(dec_rs2), .dec_uses_rs1(dec_uses_rs1), .dec_uses_rs2(dec_uses_rs2), .dec_rd(dec_rd),
      .dec_rd1(dec_rd1), .dec_rd2(dec_rd2), .dec_imm(dec_imm), .dec_ctrl(dec_ctrl),
      .dec_mem_read(dec_mem_read), .dec_reg_write(dec_reg_write), .flush(flush), .ext_stall(ext_stall),
      .ex_valid(s_ex_valid), .ex_pc(s_ex_pc), .ex_rd1(s_ex_rd1), .ex_rd2(s_ex_rd2), .ex_imm(s_ex_imm),
      .ex_rs1(s_ex_rs1), .ex_rs2(s_ex_rs2), .ex_rd(s_ex_rd), .ex_ctrl(s_ex_ctrl),
      .ex_mem_read(s_ex_mem_read), .ex_reg_write(s_ex_reg_write), .hold_id(s_hold_id),
      .stall_count(s_stall_count));

   // Model of the instruction sitting in EX
   typedef struct packed {
      logic valid;
      logic [31:0] pc, rd1, rd2, imm;
      logic [4:0] rs1, rs2, rd;
      logic [7:0] ctrl;
      logic mr, rw;
   } ex_t;

   ex_t m;
   int unsigned m_cnt;
   int n_cmp, n_bad;
   int c_before;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit model_hazard();
      bit dep;
      dep = (dec_uses_rs1 && dec_rs1 == m.rd) || (dec_uses_rs2 && dec_rs2 == m.rd);
      return m.valid && m.mr && (m.rd != 5'd0) && dec_valid && dep;
   endfunction

   task automatic check_all();
      check("ex_valid", ex_valid, m.valid);
      check("ex_pc", ex_pc, m.pc);
      check("ex_rd1", ex_rd1, m.rd1);
      check("ex_rd2", ex_rd2, m.rd2);
      check("ex_imm", ex_imm, m.imm);
      check("ex_rs1", ex_rs1, m.rs1);
      check("ex_rs2", ex_rs2, m.rs2);
      check("ex_rd", ex_rd, m.rd);
      check("ex_ctrl", ex_ctrl, m.ctrl);
      check("ex_mem_read", ex_mem_read, m.mr);
      check("ex_reg_write", ex_reg_write, m.rw);
      check("stall_count", stall_count, (m_cnt > 65535) ? 65535 : m_cnt);
      check("sat_stall_count", s_stall_count, (m_cnt > 3) ? 3 : m_cnt);
      check("sat_ex_valid", s_ex_valid, m.valid);
      check("sat_ex_rd", s_ex_rd, m.rd);
   endtask

   // One clock: check hold_id on settled inputs, advance the model, check registered outputs
   task automatic step();
      bit hz;
      ex_t nx;
      #1;
      hz = model_hazard();
      check("hold_id", hold_id, ext_stall || (hz && !flush));
      check("sat_hold_id", s_hold_id, ext_stall || (hz && !flush));
      @(posedge clk);
      nx = '0;
      if (reset) begin
         m_cnt = 0;
      end else if (flush) begin
         nx = '0;
      end else if (ext_stall) begin
         nx = m;
      end else if (hz) begin
         m_cnt++;
      end else begin
         nx.valid = dec_valid;
         nx.pc = dec_pc;
         nx.rd1 = dec_rd1;
         nx.rd2 = dec_rd2;
         nx.imm = dec_imm;
         nx.rs1 = dec_rs1;
         nx.rs2 = dec_rs2;
         nx.rd = dec_rd;
         nx.ctrl = dec_ctrl;
         nx.mr = dec_mem_read && dec_valid;
         nx.rw = dec_reg_write && dec_valid;
      end
      m = nx;
      #1;
      check_all();
   endtask

   // Random payload, no register reads, not a load
   task automatic rand_dec();
      dec_valid = 1'($urandom);
      dec_pc = $urandom;
      dec_rs1 = 5'($urandom);
      dec_rs2 = 5'($urandom);
      dec_uses_rs1 = 1'b0;
      dec_uses_rs2 = 1'b0;
      dec_rd = 5'($urandom);
      dec_rd1 = $urandom;
      dec_rd2 = $urandom;
      dec_imm = $urandom;
      dec_ctrl = 8'($urandom);
      dec_mem_read = 1'b0;
      dec_reg_write = 1'($urandom);
   endtask

   task automatic load_x(input logic [4:0] rd);
      rand_dec();
      dec_valid = 1'b1;
      dec_mem_read = 1'b1;
      dec_reg_write = 1'b1;
      dec_rd = rd;
   endtask

   task automatic use_rs1(input logic [4:0] rs);
      rand_dec();
      dec_valid = 1'b1;
      dec_uses_rs1 = 1'b1;
      dec_rs1 = rs;
      dec_rs2 = 5'd0;
   endtask

   logic [1:0] sat_exp [5];

   initial begin
      n_cmp = 0;
      n_bad = 0;
      m = '0;
      m_cnt = 0;
      flush = 1'b0;
      ext_stall = 1'b0;
      reset = 1'b1;
      rand_dec();
      dec_uses_rs1 = 1'b1;
      dec_mem_read = 1'b1;
      step();
      rand_dec();
      step();
      check("rst_ex_valid", ex_valid, 1'b0);
      check("rst_stall_count", stall_count, 16'd0);

      reset = 1'b0;
      rand_dec();
      dec_valid = 1'b1;
      dec_rd = 5'd5;
      dec_pc = 32'h100;
      step();
      check("first_ex_valid", ex_valid, 1'b1);
      check("first_ex_rd", ex_rd, 5'd5);
      check("first_ex_pc", ex_pc, 32'h100);

      // Load-use: one bubble, then the dependent instruction issues
      load_x(5'd7);
      step();
      use_rs1(5'd7);
      #1 check("lu_hold", hold_id, 1'b1);
      step();
      check("lu_bubble_valid", ex_valid, 1'b0);
      check("lu_bubble_rw", ex_reg_write, 1'b0);
      check("lu_count", stall_count, 16'd1);
      step();
      check("lu_issue_rs1", ex_rs1, 5'd7);
      check("lu_issue_valid", ex_valid, 1'b1);
      check("lu_hold_after", hold_id, 1'b0);

      // No false stall: rd=x0 and an unused matching rs2
      load_x(5'd0);
      step();
      use_rs1(5'd0);
      #1 check("x0_hold", hold_id, 1'b0);
      step();
      load_x(5'd7);
      step();
      use_rs1(5'd3);
      dec_rs2 = 5'd7;
      #1 check("unused_rs2_hold", hold_id, 1'b0);
      step();

      // Flush beats hazard
      load_x(5'd9);
      step();
      use_rs1(5'd1);
      dec_uses_rs2 = 1'b1;
      dec_rs2 = 5'd9;
      flush = 1'b1;
      c_before = m_cnt;
      #1 check("fh_hold", hold_id, 1'b0);
      step();
      flush = 1'b0;
      check("fh_bubble", ex_valid, 1'b0);
      check("fh_count", stall_count, c_before);

      // ext_stall freezes EX for three cycles
      rand_dec();
      dec_valid = 1'b1;
      dec_pc = 32'h200;
      step();
      ext_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rand_dec();
         #1 check("es_hold", hold_id, 1'b1);
         step();
         check("es_pc", ex_pc, 32'h200);
      end
      ext_stall = 1'b0;
      rand_dec();
      dec_valid = 1'b1;
      dec_pc = 32'h300;
      step();
      check("es_release_pc", ex_pc, 32'h300);

      // Flush with ext_stall: bubble loads, hold_id still asserted
      flush = 1'b1;
      ext_stall = 1'b1;
      #1 check("fs_hold", hold_id, 1'b1);
      step();
      check("fs_bubble", ex_valid, 1'b0);
      flush = 1'b0;
      ext_stall = 1'b0;

      // Saturation on the 2-bit counter instance
      reset = 1'b1;
      rand_dec();
      step();
      reset = 1'b0;
      sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3; sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;
      for (int k = 0; k < 5; k++) begin
         load_x(5'd7);
         step();
         use_rs1(5'd7);
         step();
         check("sat_seq", s_stall_count, sat_exp[k]);
         step();
      end
      check("sat_main_count", stall_count, 16'd5);

      // Random traffic with small register indices to provoke hazards
      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(0, 79) == 0);
         flush = ($urandom_range(0, 7) == 0);
         ext_stall = ($urandom_range(0, 5) == 0);
         rand_dec();
         dec_valid = ($urandom_range(0, 4) != 0);
         dec_rs1 = 5'($urandom_range(0, 3));
         dec_rs2 = 5'($urandom_range(0, 3));
         dec_rd = 5'($urandom_range(0, 3));
         dec_uses_rs1 = 1'($urandom);
         dec_uses_rs2 = 1'($urandom);
         dec_mem_read = 1'($urandom);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
